// File: rtl/pad_pixel_feeder.sv
// pad_pixel_feeder: streams a zero-padded LxL raster of an internal im x im image on a data_request pull handshake.
// Optional macro FEEDER_PADVAL_EN adds a pad_val input latched on start and used for border beats.
module pad_pixel_feeder #(
    parameter int N      = 7,
    parameter int im     = 28,
    parameter int stride = 5,
    parameter int img    = im + (stride - 1),
    parameter int ADDR_W = 10
) (
`ifdef FEEDER_PADVAL_EN
    input  logic [N:0]        pad_val,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N:0]        wr_data,
    input  logic              start,
    input  logic [11:0]       img_len,
    input  logic              data_request,
    input  logic              conv_fin,
    output logic [N:0]        data,
    output logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [11:0] IM_L  = 12'(im);
    localparam logic [11:0] IMG_L = 12'(img);
    localparam logic [ADDR_W-1:0] IM_A = ADDR_W'(im);

    logic [N:0]        mem [0:2**ADDR_W-1];
    logic [1:0]        state_q, state_d;
    logic [11:0]       len_q, len_d, pad_lo_q, pad_lo_d, row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d, rd_addr;
    logic [N:0]        data_q, data_d, pad_px;
    logic              valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic              start_ok, accept, row_in, col_in, last_col, last_beat;

    assign start_ok  = img_len >= IM_L && img_len <= IMG_L;
    assign accept    = state_q == STREAM && data_request && !conv_fin;
    assign row_in    = row_q >= pad_lo_q && row_q < pad_lo_q + IM_L;
    assign col_in    = col_q >= pad_lo_q && col_q < pad_lo_q + IM_L;
    assign last_col  = col_q == len_q - 12'd1;
    assign last_beat = last_col && row_q == len_q - 12'd1;
    assign rd_addr   = base_q + ADDR_W'(col_q - pad_lo_q);

`ifdef FEEDER_PADVAL_EN
    logic [N:0] pad_q;
    // border value captured together with the accepted start
    always_ff @(posedge clk) begin
        if (reset)
            pad_q <= '0;
        else if (state_q == IDLE && start && start_ok)
            pad_q <= pad_val;
    end
    assign pad_px = pad_q;
`else
    assign pad_px = '0;
`endif

    // image buffer: host writes land only while idle
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE)
            mem[wr_addr] <= wr_data;
    end

    // next-state: config latch on start, raster walk with a running row base instead of a multiplier
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pad_lo_d = pad_lo_q;
        row_d    = row_q;
        col_d    = col_q;
        base_d   = base_q;
        err_d    = err_q;
        valid_d  = accept;
        done_d   = accept && last_beat;
        data_d   = accept ? (row_in && col_in ? mem[rd_addr] : pad_px) : data_q;
        if (state_q == IDLE && start) begin
            err_d = !start_ok;
            if (start_ok) begin
                state_d  = STREAM;
                len_d    = img_len;
                pad_lo_d = (img_len - IM_L) >> 1;
                row_d    = '0;
                col_d    = '0;
                base_d   = '0;
            end
        end else if (state_q == STREAM) begin
            if (conv_fin)
                state_d = IDLE;
            else if (accept) begin
                col_d   = last_col ? 12'd0 : col_q + 12'd1;
                row_d   = last_col ? row_q + 12'd1 : row_q;
                base_d  = last_col && row_in ? base_q + IM_A : base_q;
                state_d = last_beat ? DONE : STREAM;
            end
        end else if (state_q == DONE)
            state_d = IDLE;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            pad_lo_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            base_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            pad_lo_q <= pad_lo_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_q   <= base_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = state_q == STREAM;
    assign done       = done_q;
    assign cfg_err    = err_q;
endmodule

// File: tb/tb_pad_pixel_feeder.sv
// tb_pad_pixel_feeder: table spot checks, hand sequences and randomized pull patterns against a padded-raster model.
module tb_pad_pixel_feeder;
    localparam int IM = 28;
`ifdef FEEDER_PADVAL_EN
    localparam logic [7:0] PADV = 8'h7F;
`else
    localparam logic [7:0] PADV = 8'h00;
`endif

    logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, data_request = 1'b0, conv_fin = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [11:0] img_len = '0;
    logic [7:0] data;
    logic       data_valid, busy, done, cfg_err;
`ifdef FEEDER_PADVAL_EN
    logic [7:0] pad_val = PADV;
`endif

    int checks = 0, errors = 0;
    logic [7:0] mem_m [0:IM*IM-1];
    logic [7:0] got [$];

    typedef struct { int len; int idx; logic [7:0] exp; } spot_t;
    typedef struct { int len; logic err; logic bsy; } cfg_t;
    spot_t spots [7];
    cfg_t  cfgs  [6];

    pad_pixel_feeder dut (
`ifdef FEEDER_PADVAL_EN
        .pad_val(pad_val),
`endif
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .img_len(img_len), .data_request(data_request), .conv_fin(conv_fin),
        .data(data), .data_valid(data_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // padded raster pixel k for side L, derived directly from the border geometry
    function automatic logic [7:0] model(input int L, input int k);
        int p, r, c;
        p = (L - IM) / 2;
        r = k / L;
        c = k % L;
        if (r >= p && r < p + IM && c >= p && c < p + IM)
            return mem_m[(r - p) * IM + (c - p)];
        return PADV;
    endfunction

    task automatic load(input bit rnd);
        for (int i = 0; i < IM * IM; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_addr = 10'(i);
            wr_data = rnd ? 8'($urandom) : 8'((i + 1) % 256);
            mem_m[i] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0: request held, 1: every other cycle, 2: random; wmode 1: write in stream, 2: write with start
    task automatic stream(input int L, input int mode, input int abort_at, input int wmode, input logic [7:0] wval);
        int total, acc, beats, dones, cyc;
        bit req_prev;
        total = abort_at > 0 ? abort_at : L * L;
        acc = 0; beats = 0; dones = 0; cyc = 0;
        got.delete();
        @(negedge clk);
        start = 1'b1;
        img_len = 12'(L);
        if (wmode == 2) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = wval; mem_m[0] = wval;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        while (beats < total && cyc < 10000) begin
            data_request = acc < total && (mode == 0 || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(1) == 1));
            if (wmode == 1 && cyc < 4) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = wval;
            end else
                wr_en = 1'b0;
            acc += int'(data_request);
            req_prev = data_request;
            @(negedge clk);
            cyc++;
            chk("valid_follows_request", data_valid, req_prev);
            if (data_valid) begin
                chk("beat_value", data, model(L, beats));
                got.push_back(data);
                beats++;
            end
            dones += int'(done);
            chk("busy_in_stream", busy, abort_at > 0 || beats < total);
            chk("done_on_last_beat", done, abort_at == 0 && data_valid && beats == total);
        end
        data_request = 1'b0;
        wr_en = 1'b0;
        chk("beat_total", beats, total);
        chk("done_pulses", dones, abort_at > 0 ? 0 : 1);
        if (abort_at > 0) conv_fin = 1'b1;
        @(negedge clk);
        conv_fin = 1'b0;
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("valid_after", data_valid, 0);
    endtask

    task automatic spot(input int L);
        chk("run_length", got.size(), L * L);
        for (int i = 0; i < 7; i++)
            if (spots[i].len == L && got.size() > spots[i].idx)
                chk($sformatf("spot_L%0d_beat%0d", L, spots[i].idx), got[spots[i].idx], spots[i].exp);
    endtask

    initial begin
        spots[0] = '{32, 0, PADV};
        spots[1] = '{32, 66, 8'd1};
        spots[2] = '{32, 93, 8'd28};
        spots[3] = '{32, 957, 8'd16};
        spots[4] = '{29, 0, 8'd1};
        spots[5] = '{29, 28, PADV};
        spots[6] = '{29, 812, PADV};
        cfgs[0] = '{27, 1'b1, 1'b0};
        cfgs[1] = '{33, 1'b1, 1'b0};
        cfgs[2] = '{28, 1'b0, 1'b1};
        cfgs[3] = '{0, 1'b1, 1'b0};
        cfgs[4] = '{4095, 1'b1, 1'b0};
        cfgs[5] = '{31, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_data", data, 0);
        chk("reset_valid", data_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cfg_err", cfg_err, 0);
        reset = 1'b0;
        data_request = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ignores_request", data_valid, 0);
        end
        data_request = 1'b0;

        load(1'b0);
        stream(32, 0, 0, 0, 8'h00);
        spot(32);
        stream(29, 0, 0, 0, 8'h00);
        spot(29);
        stream(32, 1, 0, 0, 8'h00);
        spot(32);

        stream(32, 0, 100, 0, 8'h00);
        stream(32, 0, 0, 0, 8'h00);
        spot(32);

        foreach (cfgs[i]) begin
            @(negedge clk);
            start = 1'b1;
            img_len = 12'(cfgs[i].len);
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("cfg_err_len%0d", cfgs[i].len), cfg_err, cfgs[i].err);
            chk($sformatf("cfg_busy_len%0d", cfgs[i].len), busy, cfgs[i].bsy);
            conv_fin = 1'b1;
            @(negedge clk);
            conv_fin = 1'b0;
        end

        stream(32, 0, 0, 1, 8'hAA);
        stream(32, 0, 0, 0, 8'h00);
        chk("stream_write_dropped", got[66], 8'd1);
        stream(32, 0, 0, 2, 8'h55);
        chk("write_with_start_visible", got[66], 8'h55);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'd1; mem_m[0] = 8'd1;
        @(negedge clk);
        wr_en = 1'b0;

        @(negedge clk);
        start = 1'b1;
        img_len = 12'd32;
        @(negedge clk);
        start = 1'b0;
        data_request = 1'b1;
        repeat (70) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        data_request = 1'b0;
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", data_valid, 0);
        chk("midreset_done", done, 0);
        chk("midreset_data", data, 0);
        stream(32, 0, 0, 0, 8'h00);
        spot(32);

        for (int t = 0; t < 4; t++) begin
            load(1'b1);
            stream(28 + t, 2, 0, 0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pad_pixel_feeder.md
Name: pad_pixel_feeder

Overview:
- Pixel source for full_conv: answers its data_request/data pull handshake with a padded image stream.
- Holds an unpadded im x im image in an internal buffer, written through a simple write port.
- On start, streams an img_len x img_len raster (row-major) and inserts the zero border on the fly, so the host never stores padded images.
- Sits between the host/DMA image loader and the data/data_valid inputs of full_conv.

Parameters:
N, 7, data MSB index (pixel width N+1)
im, 28, stored (unpadded) image side length
stride, 5, maximum kernel side supported
img, im+(stride-1), maximum padded side length
ADDR_W, 10, buffer address width; must satisfy 2**ADDR_W >= im*im

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_W  buffer write address, raster index row*im+col
wr_data  input  N+1  buffer write data
start  input  1  one-cycle pulse to begin streaming
img_len  input  12  padded side length, sampled on start
data_request  input  1  pull request from full_conv
conv_fin  input  1  consumer finished/abort
data  output  N+1  pixel to full_conv
data_valid  output  1  data qualifier, one beat per accepted request
busy  output  1  high in STREAM
done  output  1  one-cycle pulse after last beat
cfg_err  output  1  sticky: start rejected for bad img_len

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: data=0, data_valid=0, busy=0, done=0, cfg_err=0, state IDLE. Buffer contents are not cleared.
- Reset mid-stream returns to IDLE immediately. No done pulse.
- FSM states IDLE, STREAM, DONE.
- IDLE:
  - start with im <= img_len <= img: latch L=img_len, pad_lo=(L-im)>>1, set row=col=0, clear cfg_err, go to STREAM.
  - start with img_len out of range: set cfg_err=1 and stay in IDLE.
  - data_request is ignored; data_valid stays 0.
- STREAM:
  - Each cycle with data_request=1, the current (row,col) is accepted.
  - Latency is exactly 1 cycle: data_valid=1 on the next cycle, with data = buf[(row-pad_lo)*im + (col-pad_lo)] when pad_lo <= row,col < pad_lo+im, else 0.
  - data_valid is 0 in every cycle that follows a cycle without a request. data holds its last value.
  - Raster advance: col increments; when col=L-1 it wraps to 0 and row increments.
  - Bottom/right pad = L-im-pad_lo, so an odd total puts the extra pad row/column at the bottom/right.
  - Address generation uses no multiplier: a running row-base register is cleared at start and incremented by im after each interior row completes.
  - When the beat with row=col=L-1 is accepted, go to DONE.
  - conv_fin=1 in STREAM aborts to IDLE: busy=0, no done, any in-flight beat still completes next cycle.
  - start is ignored while in STREAM.
- DONE: lasts one cycle. The final data_valid beat and done=1 occur in this same cycle; then go to IDLE.
- Writes:
  - wr_en is honoured only in IDLE; writes in STREAM/DONE are dropped.
  - A write and a start in the same IDLE cycle: the write lands first and is visible to the stream.
- Totals: exactly L*L data_valid beats per unaborted run. pad_lo stays <= (img-im)>>1.

Optional Feature:
- Macro: FEEDER_PADVAL_EN.
- Defined: adds input pad_val [N:0], sampled on start; border beats output the latched pad_val instead of 0.
- Undefined: no port, and border beats are always 0.

Test Plan:
- Load buf[i]=(i+1) mod 256, start with img_len=32 and data_request held high -> 1024 beats. Beat 0 = 0, beat 66 (row2,col2) = 1, beat 93 (row2,col29) = 28, beat 957 (row29,col29) = 784 mod 256 = 16. done is asserted in the 1024th-beat cycle; busy then drops.
- Same image, img_len=29 -> pad_lo=0. Beat 0 = 1, beat 28 = 0 (right pad), beat 812 (row28) = 0, total 841 beats.
- img_len=32 with data_request toggling every other cycle -> same 1024-value sequence as the first test; data_valid only in cycles following a request.
- After 100 accepted beats, pulse conv_fin -> data_valid for the 100th beat only, then IDLE; done never pulses. A new start reruns from beat 0.
- start with img_len=27, then with img_len=33 -> cfg_err=1, busy stays 0. A later valid start clears cfg_err.
- wr_en to addr 0 with value 0xAA during STREAM -> buffer unchanged and the next run's beat 66 = 1. With FEEDER_PADVAL_EN and pad_val=0x7F -> beat 0 = 0x7F.
